// File: rtl/nes_joypad_responder.sv
// NES controller emulation: debounces eight buttons and answers the console's
// strobe/clock protocol with an active-low serial report on joy_data.
module nes_joypad_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 21477
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] buttons,
  input  logic       joy_strobe,
  input  logic       joy_clock,
  output logic       joy_data,
  output logic [7:0] latched_buttons,
  output logic       read_done
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {StLoad, StShift} state_e;

  // Console pin synchronizers; clock flops reset high so a high idle clock
  // never looks like a rising edge when reset is released.
  logic strobe_s1_q, strobe_s2_q;
  logic jclk_s1_q, jclk_s2_q, jclk_h_q;
  logic clk_rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      strobe_s1_q <= 1'b0;
      strobe_s2_q <= 1'b0;
      jclk_s1_q   <= 1'b1;
      jclk_s2_q   <= 1'b1;
      jclk_h_q    <= 1'b1;
    end else begin
      strobe_s1_q <= joy_strobe;
      strobe_s2_q <= strobe_s1_q;
      jclk_s1_q   <= joy_clock;
      jclk_s2_q   <= jclk_s1_q;
      jclk_h_q    <= jclk_s2_q;
    end
  end

  assign clk_rise = jclk_s2_q & ~jclk_h_q;

  // Button synchronizers and per-bit debounce counters.
  logic [7:0]      btn_s1_q, btn_s2_q;
  logic [7:0]      deb_q, deb_d;
  logic [CntW-1:0] deb_cnt_q [8];
  logic [CntW-1:0] deb_cnt_d [8];

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 8; i++) begin
      deb_cnt_d[i] = '0;
      if (btn_s2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          deb_d[i] = btn_s2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      deb_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      btn_s1_q <= buttons;
      btn_s2_q <= btn_s1_q;
      deb_q    <= deb_d;
      for (int i = 0; i < 8; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // Report FSM and shift register.
  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] shift_cnt_q, shift_cnt_d;
  logic [7:0] latched_q, latched_d;
  logic       read_done_q, read_done_d;
  logic       joy_data_q, joy_data_d;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    shift_cnt_d = shift_cnt_q;
    latched_d   = latched_q;
    read_done_d = 1'b0;

    // A high strobe always wins over a coincident clock edge.
    if (strobe_s2_q) begin
      state_d     = StLoad;
      sr_d        = deb_q;
      shift_cnt_d = 4'd0;
      latched_d   = deb_q;
    end else begin
      unique case (state_q)
        StLoad: begin
          state_d = StShift;
        end
        StShift: begin
          if (clk_rise) begin
            if (shift_cnt_q < 4'd8) begin
              sr_d        = {1'b0, sr_q[7:1]};
              shift_cnt_d = shift_cnt_q + 4'd1;
              read_done_d = (shift_cnt_q == 4'd7);
            end else begin
              sr_d = '0;
            end
          end
        end
        default: state_d = StLoad;
      endcase
    end

    joy_data_d = (shift_cnt_q == 4'd8) ? 1'b0 : ~sr_q[0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StLoad;
      sr_q        <= '0;
      shift_cnt_q <= '0;
      latched_q   <= '0;
      read_done_q <= 1'b0;
      joy_data_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      shift_cnt_q <= shift_cnt_d;
      latched_q   <= latched_d;
      read_done_q <= read_done_d;
      joy_data_q  <= joy_data_d;
    end
  end

  assign joy_data        = joy_data_q;
  assign latched_buttons = latched_q;
  assign read_done       = read_done_q;

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Bench for nes_joypad_responder: expected report bits are queued at each
// strobe and compared as the bench clocks the report out.
module tb_nes_joypad_responder;

  localparam int unsigned Deb = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] buttons = '0;
  logic       joy_strobe = 1'b0;
  logic       joy_clock = 1'b1;
  logic       joy_data;
  logic [7:0] latched_buttons;
  logic       read_done;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned rd_count = 0;
  logic        exp_q[$];

  nes_joypad_responder #(.DEBOUNCE_CYCLES(Deb)) dut (
    .clock          (clock),
    .reset          (reset),
    .buttons        (buttons),
    .joy_strobe     (joy_strobe),
    .joy_clock      (joy_clock),
    .joy_data       (joy_data),
    .latched_buttons(latched_buttons),
    .read_done      (read_done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (read_done) rd_count <= rd_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_strobe();
    joy_strobe = 1'b1;
    tick(6);
    joy_strobe = 1'b0;
    tick(6);
  endtask

  task automatic clk_pulse();
    joy_clock = 1'b0;
    tick(4);
    joy_clock = 1'b1;
    tick(6);
  endtask

  task automatic push_report(input logic [7:0] btn);
    for (int i = 0; i < 8; i++) exp_q.push_back(~btn[i]);
  endtask

  task automatic read_bits(input string tag, input int n);
    logic e;
    for (int i = 0; i < n; i++) begin
      check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b1;
      check($sformatf("%s_bit%0d", tag, i), 32'(joy_data), 32'(e));
      clk_pulse();
    end
  endtask

  int unsigned rd0;

  initial begin
    tick(3);
    check("rst_joy_data", 32'(joy_data), 32'd1);
    check("rst_latched", 32'(latched_buttons), 32'd0);
    check("rst_read_done", 32'(read_done), 32'd0);
    reset = 1'b0;
    tick(4);
    check("post_rst_joy_data", 32'(joy_data), 32'd1);

    // Basic report of A and Right, then overrun pulses.
    buttons = 8'b1000_0001;
    tick(Deb + 10);
    do_strobe();
    check("latch_81", 32'(latched_buttons), 32'h81);
    push_report(8'h81);
    rd0 = rd_count;
    read_bits("rep81", 7);
    check("no_done_before_8th", rd_count - rd0, 32'd0);
    read_bits("rep81_last", 1);
    check("done_once", rd_count - rd0, 32'd1);
    for (int i = 0; i < 3; i++) exp_q.push_back(1'b0);
    read_bits("overrun", 3);
    check("overrun_data", 32'(joy_data), 32'd0);
    check("overrun_no_done", rd_count - rd0, 32'd1);

    // Debounce: a short glitch is rejected, a long hold is accepted.
    buttons = 8'h00;
    tick(Deb + 10);
    buttons = 8'h01;
    tick(Deb - 2);
    buttons = 8'h00;
    tick(2);
    do_strobe();
    check("deb_short", 32'(latched_buttons), 32'h00);
    buttons = 8'h01;
    tick(Deb + 2);
    do_strobe();
    check("deb_long", 32'(latched_buttons), 32'h01);

    // Clock edges during strobe are ignored.
    exp_q.delete();
    joy_strobe = 1'b1;
    tick(4);
    for (int i = 0; i < 4; i++) clk_pulse();
    joy_strobe = 1'b0;
    tick(6);
    push_report(8'h01);
    read_bits("strobe_clk", 8);

    // Reset mid-report discards the partial shift.
    do_strobe();
    push_report(8'h01);
    read_bits("pre_rst", 3);
    reset = 1'b1;
    tick(2);
    check("mid_rst_joy_data", 32'(joy_data), 32'd1);
    check("mid_rst_latched", 32'(latched_buttons), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    tick(Deb + 10);
    check("mid_rst_idle", 32'(joy_data), 32'd1);
    rd0 = rd_count;
    do_strobe();
    push_report(8'h01);
    read_bits("after_rst", 8);
    check("after_rst_done", rd_count - rd0, 32'd1);

    // Button changes between strobes do not disturb the current report.
    do_strobe();
    push_report(8'h01);
    buttons = 8'h02;
    tick(Deb + 10);
    check("hold_latched", 32'(latched_buttons), 32'h01);
    read_bits("cur_a", 8);
    do_strobe();
    check("next_latched", 32'(latched_buttons), 32'h02);
    push_report(8'h02);
    read_bits("next_b", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nes_joypad_responder.md
NES_JOYPAD_RESPONDER -- requirements
Module: nes_joypad_responder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 21477, number of consecutive stable clock cycles a button input needs before its debounced value changes (about 1 ms at 21.477 MHz).
REQ-002 Port clock  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port buttons  input  8  raw asynchronous button levels, active-high: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
REQ-005 Port joy_strobe  input  1  asynchronous latch/load request from the console; high means load.
REQ-006 Port joy_clock  input  1  asynchronous shift clock from the console; idles high, shifts on the rising edge.
REQ-007 Port joy_data  output  1  serial data to the console, active-low: 0 means pressed or post-report fill.
REQ-008 Port latched_buttons  output  8  debounced button snapshot captured at the last strobe.
REQ-009 Port read_done  output  1  one-cycle pulse when the 8th shift completes.

Function
REQ-010 joy_strobe and joy_clock SHALL each pass through a 2-flop synchronizer; the first stage feeds the second, and edge detection SHALL use the second stage and a third history flop.
REQ-011 Each buttons bit SHALL pass through a 2-flop synchronizer, then through its own debounce counter (width ceil(log2(DEBOUNCE_CYCLES+1))).
- Counter clears whenever the synced bit equals the debounced bit.
- When the counter reaches DEBOUNCE_CYCLES-1 while the bits still differ, the debounced bit SHALL take the synced value on the next edge and the counter SHALL clear.
REQ-012 A 2-state FSM {LOAD, SHIFT} SHALL control an 8-bit shift register sr and a 4-bit counter cnt.
REQ-013 LOAD state: every cycle that synced strobe is high, sr SHALL take the debounced buttons, cnt SHALL clear to 0, and latched_buttons SHALL take the debounced buttons.
REQ-014 LOAD to SHIFT: SHALL occur on the cycle synced strobe is observed low.
REQ-015 SHIFT to LOAD: SHALL occur on any cycle synced strobe is high, with the same action as REQ-013.
REQ-016 In SHIFT, a synced joy_clock rising edge with cnt<8 SHALL shift sr right with 0 inserted at the MSB and increment cnt.
REQ-017 In SHIFT, when cnt is already 8, clock edges SHALL leave sr at 0 and cnt saturated at 8 (no wrap).
REQ-018 joy_data SHALL be a registered ~sr[0], updated one cycle after sr changes.
- Total latency from a pin edge to joy_data is 4 clock cycles (2 sync, 1 sr, 1 output).
- Once cnt=8, joy_data SHALL be 0.
REQ-019 read_done SHALL pulse high for exactly one cycle on the shift that moves cnt from 7 to 8.
REQ-020 A strobe-high cycle coincident with a clock rising edge SHALL perform the load only; no shift occurs.
REQ-021 A clock rising edge while in LOAD, or while synced strobe is high, SHALL be ignored.
REQ-022 A button change between strobes SHALL NOT affect sr or latched_buttons until the next load.

Reset
REQ-023 Reset SHALL set the following values:
- FSM=LOAD, sr=0, cnt=0.
- Debounced buttons=0 and all debounce counters=0.
- latched_buttons=0, read_done=0, joy_data=1.
REQ-024 During reset, the strobe synchronizer flops SHALL reset to 0 and the clock synchronizer and history flops SHALL reset to 1, so deasserting reset with joy_clock high produces no spurious edge.
REQ-025 Reset asserted mid-report SHALL take effect on the next edge, discarding the partial shift; the first post-reset read requires a new strobe.

Verification
REQ-026 Hold buttons=8'b1000_0001 for more than DEBOUNCE_CYCLES, pulse strobe, then apply 8 clock pulses -> joy_data sequence 0,1,1,1,1,1,1,0, and read_done pulses once on the 8th edge.
REQ-027 Apply 3 further clock pulses after REQ-026 -> joy_data stays 0, cnt stays 8, no read_done pulse.
REQ-028 Toggle buttons[0] for DEBOUNCE_CYCLES-2 cycles, then strobe -> latched_buttons[0]=0; hold for DEBOUNCE_CYCLES+2 cycles, then strobe -> latched_buttons[0]=1.
REQ-029 Hold strobe high while toggling joy_clock 4 times, then drop strobe -> joy_data still reports the A bit first.
REQ-030 Assert reset after the 3rd shift -> joy_data=1, latched_buttons=0; a following strobe plus 8 clocks reproduces the full sequence.
REQ-031 Change buttons from 0x01 to 0x02 after the strobe falls -> the current report still shows A only; the next strobe reports B only.
